// File: rtl/clk_wiz_rst_seq_if.sv
// Handshake bundle between the clock-wizard reset sequencer and its surroundings.
// The slave modport is the sequencer; the master modport drives lock/control inputs.
interface clk_wiz_rst_seq_if;
   logic       i_locked;
   logic       i_force_reset;
   logic       i_retry;
   logic       o_mmcm_resetn;
   logic       o_sys_rst;
   logic       o_ready;
   logic       o_fail;
   logic       o_lock_lost;
   logic [3:0] o_retry_cnt;
   logic [7:0] o_loss_cnt;
   logic [2:0] o_state;

   modport slave (
      input  i_locked, i_force_reset, i_retry,
      output o_mmcm_resetn, o_sys_rst, o_ready, o_fail, o_lock_lost,
             o_retry_cnt, o_loss_cnt, o_state
   );

   modport master (
      output i_locked, i_force_reset, i_retry,
      input  o_mmcm_resetn, o_sys_rst, o_ready, o_fail, o_lock_lost,
             o_retry_cnt, o_loss_cnt, o_state
   );
endinterface

// File: rtl/clk_wiz_rst_seq.sv
// Reset/lock sequencer for the clocking wizard: pulses its resetn, qualifies locked,
// retries on timeout or lock loss, and releases a system reset once clocks are good.
module clk_wiz_rst_seq #(
   parameter int unsigned RST_CYCLES    = 8,
   parameter int unsigned LOCK_TIMEOUT  = 1000,
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned MAX_RETRY     = 3,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic               i_sys_clk,
   input  logic               i_rst,
   clk_wiz_rst_seq_if.slave   bus
);

   localparam int unsigned CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
   localparam int unsigned RTY_W     = 4;
   localparam int unsigned LOSS_W    = 8;

   typedef enum logic [2:0] {
      S_RESET_HOLD = 3'd0,
      S_WAIT_LOCK  = 3'd1,
      S_STABLE     = 3'd2,
      S_RUN        = 3'd3,
      S_FAIL       = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [RTY_W-1:0]     retry_q, retry_d;
   logic [LOSS_W-1:0]    loss_q, loss_d;
   logic                 lost_q, lost_d;
   logic                 resetn_q, sys_rst_q, ready_q, fail_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                 lk;
   logic                 fail_attempt;

   assign lk = sync_q[SYNC_STAGES-1];

   // Next-state: one shared timer restarts on every state change.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + CNT_W'(1);
      retry_d      = retry_q;
      loss_d       = loss_q;
      lost_d       = 1'b0;
      fail_attempt = 1'b0;
      case (state_q)
         S_RESET_HOLD: begin
            if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end
         end
         S_WAIT_LOCK: begin
            if (lk) begin
               state_d = S_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
               fail_attempt = 1'b1;
            end
         end
         S_STABLE: begin
            if (!lk) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
               state_d = S_RUN;
               cnt_d   = '0;
               retry_d = '0;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q;
            if (!lk) begin
               fail_attempt = 1'b1;
               lost_d       = 1'b1;
               loss_d       = (loss_q == {LOSS_W{1'b1}}) ? loss_q : loss_q + LOSS_W'(1);
            end
         end
         S_FAIL: begin
            cnt_d = cnt_q;
            if (bus.i_retry) begin
               state_d = S_RESET_HOLD;
               cnt_d   = '0;
               retry_d = '0;
            end
         end
         default: begin
            state_d = S_RESET_HOLD;
            cnt_d   = '0;
         end
      endcase

      if (fail_attempt) begin
         retry_d = retry_q + RTY_W'(1);
         state_d = (retry_d == RTY_W'(MAX_RETRY)) ? S_FAIL : S_RESET_HOLD;
         cnt_d   = '0;
      end

      // A forced restart overrides any timeout or lock drop in the same cycle.
      if (bus.i_force_reset && (state_q != S_FAIL)) begin
         state_d = S_RESET_HOLD;
         cnt_d   = '0;
         retry_d = retry_q;
         loss_d  = loss_q;
         lost_d  = 1'b0;
      end
   end

   // State, counters and outputs; outputs are decoded from the next state.
   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_RESET_HOLD;
         cnt_q     <= '0;
         retry_q   <= '0;
         loss_q    <= '0;
         lost_q    <= 1'b0;
         resetn_q  <= 1'b0;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
         sync_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         loss_q    <= loss_d;
         lost_q    <= lost_d;
         resetn_q  <= (state_d == S_WAIT_LOCK) || (state_d == S_STABLE) || (state_d == S_RUN);
         sys_rst_q <= (state_d != S_RUN);
         ready_q   <= (state_d == S_RUN);
         fail_q    <= (state_d == S_FAIL);
         sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.i_locked};
      end
   end

   assign bus.o_mmcm_resetn = resetn_q;
   assign bus.o_sys_rst     = sys_rst_q;
   assign bus.o_ready       = ready_q;
   assign bus.o_fail        = fail_q;
   assign bus.o_lock_lost   = lost_q;
   assign bus.o_retry_cnt   = retry_q;
   assign bus.o_loss_cnt    = loss_q;
   assign bus.o_state       = 3'(state_q);

endmodule

// File: tb/tb_clk_wiz_rst_seq.sv
// Directed bench for clk_wiz_rst_seq: bring-up, lock loss, forced restart, glitch,
// async reset mid-STABLE, and timeout/retry into FAIL with recovery.
module tb_clk_wiz_rst_seq;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   clk_wiz_rst_seq_if bus ();

   clk_wiz_rst_seq dut (
      .i_sys_clk (clk),
      .i_rst     (rst),
      .bus       (bus.slave)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"},  32'(bus.o_state), 0);
      chk({tag, "_resetn"}, 32'(bus.o_mmcm_resetn), 0);
      chk({tag, "_sysrst"}, 32'(bus.o_sys_rst), 1);
      chk({tag, "_ready"},  32'(bus.o_ready), 0);
      chk({tag, "_fail"},   32'(bus.o_fail), 0);
      chk({tag, "_lost"},   32'(bus.o_lock_lost), 0);
      chk({tag, "_retry"},  32'(bus.o_retry_cnt), 0);
      chk({tag, "_loss"},   32'(bus.o_loss_cnt), 0);
   endtask

   initial begin
      rst               = 1'b1;
      bus.i_locked      = 1'b0;
      bus.i_force_reset = 1'b0;
      bus.i_retry       = 1'b0;
      #1;
      chk_reset_vals("por");
      step(2);
      rst = 1'b0;

      // Normal bring-up: resetn low 8 cycles, ready 19 cycles after lock edge
      step(7);
      chk("bringup_resetn_low", 32'(bus.o_mmcm_resetn), 0);
      step(1);
      chk("bringup_resetn_high", 32'(bus.o_mmcm_resetn), 1);
      chk("bringup_wait_state", 32'(bus.o_state), 1);
      step(50);
      bus.i_locked = 1'b1;
      step(18);
      chk("bringup_ready_early", 32'(bus.o_ready), 0);
      chk("bringup_sysrst_early", 32'(bus.o_sys_rst), 1);
      step(1);
      chk("bringup_ready", 32'(bus.o_ready), 1);
      chk("bringup_sysrst", 32'(bus.o_sys_rst), 0);
      chk("bringup_run_state", 32'(bus.o_state), 3);
      chk("bringup_retry", 32'(bus.o_retry_cnt), 0);

      // Lock loss in RUN
      bus.i_locked = 1'b0;
      step(2);
      chk("loss_no_pulse_yet", 32'(bus.o_lock_lost), 0);
      chk("loss_ready_still", 32'(bus.o_ready), 1);
      step(1);
      chk("loss_pulse", 32'(bus.o_lock_lost), 1);
      chk("loss_ready_low", 32'(bus.o_ready), 0);
      chk("loss_sysrst", 32'(bus.o_sys_rst), 1);
      chk("loss_cnt", 32'(bus.o_loss_cnt), 1);
      chk("loss_retry", 32'(bus.o_retry_cnt), 1);
      chk("loss_state", 32'(bus.o_state), 0);
      step(1);
      chk("loss_pulse_end", 32'(bus.o_lock_lost), 0);

      // Force reset on the cycle the timeout expires
      step(7);
      chk("force_wait_state", 32'(bus.o_state), 1);
      step(999);
      chk("force_pre_state", 32'(bus.o_state), 1);
      chk("force_pre_retry", 32'(bus.o_retry_cnt), 1);
      bus.i_force_reset = 1'b1;
      step(1);
      bus.i_force_reset = 1'b0;
      chk("force_state", 32'(bus.o_state), 0);
      chk("force_retry_kept", 32'(bus.o_retry_cnt), 1);
      chk("force_resetn", 32'(bus.o_mmcm_resetn), 0);

      // Lock glitch in STABLE: back to WAIT_LOCK, no retry counted
      step(8);
      chk("glitch_wait_state", 32'(bus.o_state), 1);
      bus.i_locked = 1'b1;
      step(10);
      bus.i_locked = 1'b0;
      step(1);
      bus.i_locked = 1'b1;
      step(18);
      chk("glitch_ready_early", 32'(bus.o_ready), 0);
      chk("glitch_resetn", 32'(bus.o_mmcm_resetn), 1);
      chk("glitch_retry_kept", 32'(bus.o_retry_cnt), 1);
      step(1);
      chk("glitch_ready", 32'(bus.o_ready), 1);
      chk("glitch_retry_clear", 32'(bus.o_retry_cnt), 0);
      chk("glitch_loss_kept", 32'(bus.o_loss_cnt), 1);

      // Async reset pulse during STABLE
      bus.i_force_reset = 1'b1;
      step(1);
      bus.i_force_reset = 1'b0;
      chk("rerun_force_state", 32'(bus.o_state), 0);
      step(9);
      chk("async_in_stable", 32'(bus.o_state), 2);
      #4;
      rst = 1'b1;
      #1;
      chk_reset_vals("async");
      #2;
      rst = 1'b0;
      step(7);
      chk("async_resetn_low", 32'(bus.o_mmcm_resetn), 0);
      step(1);
      chk("async_resetn_high", 32'(bus.o_mmcm_resetn), 1);
      step(16);
      chk("async_stable_state", 32'(bus.o_state), 2);
      step(1);
      chk("async_ready", 32'(bus.o_ready), 1);

      // Timeouts into FAIL
      bus.i_locked = 1'b0;
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(8);
      chk("to_wait_state", 32'(bus.o_state), 1);
      for (int k = 1; k <= 3; k++) begin
         step(999);
         chk("to_still_waiting", 32'(bus.o_state), 1);
         chk("to_retry_before", 32'(bus.o_retry_cnt), 32'(k - 1));
         step(1);
         chk("to_retry_after", 32'(bus.o_retry_cnt), 32'(k));
         chk("to_state_after", 32'(bus.o_state), (k < 3) ? 32'd0 : 32'd4);
         chk("to_resetn_low", 32'(bus.o_mmcm_resetn), 0);
         if (k < 3) begin
            step(7);
            chk("to_pulse_low", 32'(bus.o_mmcm_resetn), 0);
            step(1);
            chk("to_pulse_end", 32'(bus.o_mmcm_resetn), 1);
         end
      end
      chk("fail_flag", 32'(bus.o_fail), 1);
      chk("fail_sysrst", 32'(bus.o_sys_rst), 1);
      chk("fail_ready", 32'(bus.o_ready), 0);

      bus.i_force_reset = 1'b1;
      step(1);
      bus.i_force_reset = 1'b0;
      chk("fail_force_ignored", 32'(bus.o_state), 4);
      chk("fail_force_flag", 32'(bus.o_fail), 1);

      bus.i_retry = 1'b1;
      step(1);
      bus.i_retry = 1'b0;
      chk("retry_fail_clear", 32'(bus.o_fail), 0);
      chk("retry_cnt_clear", 32'(bus.o_retry_cnt), 0);
      chk("retry_state", 32'(bus.o_state), 0);
      step(7);
      chk("retry_resetn_low", 32'(bus.o_mmcm_resetn), 0);
      step(1);
      chk("retry_resetn_high", 32'(bus.o_mmcm_resetn), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_wiz_rst_seq.md
Name: clk_wiz_rst_seq

Overview:
- Reset/lock sequencer for the clocking wizard instance (clk_wiz_0) in the top level.
- Drives the wizard's active-low `resetn` and monitors its `locked` output, with lock qualification, timeout/retry, lock-loss recovery and a fail state.
- Issues a qualified system reset and a ready flag to downstream logic in the `i_sys_clk` domain.

Parameters:
- RST_CYCLES, 8: cycles `o_mmcm_resetn` is held low per attempt (≥1).
- LOCK_TIMEOUT, 1000: max cycles in WAIT_LOCK before an attempt is declared failed.
- STABLE_CYCLES, 16: consecutive synced-lock cycles required before release.
- MAX_RETRY, 3: failed attempts allowed before entering FAIL (≥1).
- SYNC_STAGES, 2: flops in the `i_locked` synchroniser (≥2).

Ports:
- i_sys_clk  in  1  system clock (100 MHz), sole clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_locked  in  1  wizard `locked`, asynchronous to `i_sys_clk`.
- i_force_reset  in  1  single-cycle pulse: restart sequence without counting a retry.
- i_retry  in  1  single-cycle pulse: leave FAIL and restart.
- o_mmcm_resetn  out  1  to wizard `resetn`, active low.
- o_sys_rst  out  1  active-high reset for downstream logic.
- o_ready  out  1  clocks qualified and running.
- o_fail  out  1  retry budget exhausted.
- o_lock_lost  out  1  one-cycle pulse when lock drops in RUN.
- o_retry_cnt  out  4  consecutive failed attempts.
- o_loss_cnt  out  8  total lock-loss events, saturates at 255.
- o_state  out  3  encoded FSM state (debug).

Behaviour:
- All outputs registered. Reset values while `i_rst`=1:
  - `o_mmcm_resetn`=0, `o_sys_rst`=1, `o_ready`=0, `o_fail`=0, `o_lock_lost`=0.
  - Both counters 0, state RESET_HOLD (`o_state`=0).
  - Synchroniser flops 0.
- `i_locked` passes through SYNC_STAGES flops. Only the synced value (`lk`) is used.
- States and encodings: RESET_HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- RESET_HOLD:
  - `o_mmcm_resetn`=0 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
  - Timers clear on entry.
- WAIT_LOCK:
  - `o_mmcm_resetn`=1; timeout counter increments each cycle.
  - `lk`=1 → STABLE.
  - Counter reaches LOCK_TIMEOUT → failed attempt.
- STABLE:
  - Counts consecutive `lk`=1 cycles. Reaching STABLE_CYCLES → RUN.
  - `lk`=0 → WAIT_LOCK with the timeout counter cleared. This is a glitch, not a failed attempt.
- RUN:
  - `o_sys_rst`=0 and `o_ready`=1, both from the cycle RUN is entered.
  - `o_retry_cnt` clears on RUN entry.
  - `lk`=0 → `o_lock_lost` pulses 1 cycle, `o_loss_cnt`+1 (saturating), failed attempt.
- Failed attempt:
  - `o_retry_cnt`+1.
  - If the new value equals MAX_RETRY → FAIL, otherwise → RESET_HOLD.
- FAIL:
  - `o_mmcm_resetn`=0, `o_sys_rst`=1, `o_ready`=0, `o_fail`=1.
  - Held until `i_rst` or `i_retry`.
  - `i_retry` → RESET_HOLD with `o_retry_cnt`=0 and `o_fail`=0 on the next cycle.
- `o_sys_rst`=1 and `o_ready`=0 in every state except RUN.
- Latency: first `i_locked` edge sampled in WAIT_LOCK to `o_ready`=1 is SYNC_STAGES+STABLE_CYCLES+1 cycles (19 at defaults).
- `i_force_reset` in any state except FAIL → RESET_HOLD next cycle. No retry increment and no `o_lock_lost`.
  - Takes priority over a simultaneous timeout or lock drop, which are then not counted.
  - Ignored in FAIL.
- `i_retry` outside FAIL is ignored.
- Asynchronous `i_rst` mid-sequence returns immediately to the reset values. On deassertion the sequence begins with a full RESET_HOLD.
- `o_retry_cnt` never exceeds MAX_RETRY. `o_loss_cnt` holds at 255.

Test Plan:
- Normal bring-up:
  - Stimulus: `i_rst` 1→0; `i_locked` rises 50 cycles after `o_mmcm_resetn` rises.
  - Response: `o_mmcm_resetn` low for exactly 8 cycles after reset release; `o_ready`=1 and `o_sys_rst`=0 exactly 19 cycles after the `i_locked` edge; `o_retry_cnt`=0.
- Lock glitch:
  - Stimulus: `i_locked` high 10 cycles, low 1 cycle, then high.
  - Response: no retry counted; `o_mmcm_resetn` stays 1; `o_ready` 19 cycles after the final rise.
- Timeout to FAIL:
  - Stimulus: `i_locked` held 0.
  - Response: three 8-cycle reset pulses separated by 1000-cycle waits; `o_retry_cnt` counts 1, 2, 3; `o_fail`=1 with `o_mmcm_resetn`=0.
  - Stimulus: `i_retry` pulse.
  - Response: `o_fail`=0, `o_retry_cnt`=0, new RESET_HOLD.
- Lock loss in RUN:
  - Stimulus: drop `i_locked` while in RUN.
  - Response: after 2 sync cycles, `o_lock_lost` 1-cycle pulse; `o_ready`=0 and `o_sys_rst`=1 the same cycle; `o_loss_cnt`=1, `o_retry_cnt`=1; relock → RUN with `o_retry_cnt`=0.
- Force reset vs. timeout:
  - Stimulus: `i_force_reset` on the same cycle the timeout expires.
  - Response: RESET_HOLD entered, `o_retry_cnt` unchanged.
- Async reset mid-STABLE:
  - Stimulus: pulse `i_rst` for 3 ns during STABLE.
  - Response: outputs return to reset values without waiting for a clock edge; full sequence restarts.
